// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO pointer helpers (Gray conversion, full compare) for both clock domains.
package fifo_pkg;
  localparam int DEF_ADDR_W = 8;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
    return b;
  endfunction
  // Full when the Gray pointers differ only in their top two bits (one lap apart).
  function automatic logic full_cmp(input logic [31:0] wg, input logic [31:0] rg, input int aw);
    logic [31:0] m;
    m = (32'd1 << (aw + 1)) - 32'd1;
    return ((wg ^ rg ^ (32'd3 << (aw - 1))) & m) == 32'd0;
  endfunction
endpackage

// File: rtl/gray_sync2.sv
// gray_sync2: two-flop synchroniser for a Gray-coded bus, sync active-low reset.
module gray_sync2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_q, s1_d, s2_q, s2_d;
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer, flags and read-pointer sync of the dual-clock FIFO.
// Define FIFO_WR_OVF_EN to add the sticky wr_ovf output.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AF_MARGIN = 4
) (
  input  logic              wrclk,
  input  logic              wrrst_n,
  input  logic              wr_req,
  input  logic [ADDR_W:0]   rdPtrGray,
  output logic [ADDR_W-1:0] wrPtr,
  output logic              wren,
  output logic [ADDR_W:0]   wrPtrGray,
  output logic              full,
  output logic              almost_full,
`ifdef FIFO_WR_OVF_EN
  output logic              wr_ovf,
`endif
  output logic [ADDR_W:0]   wr_level
);
  localparam logic [ADDR_W:0] AF_TH = (ADDR_W + 1)'((1 << ADDR_W) - AF_MARGIN);
  logic [ADDR_W:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d, level_q, level_d, rd_sync;
  logic full_q, full_d, af_q, af_d;
  gray_sync2 #(.W(ADDR_W + 1)) u_rd_sync (
    .clk  (wrclk),
    .rst_n(wrrst_n),
    .d    (rdPtrGray),
    .q    (rd_sync)
  );
  assign wren = wr_req & ~full_q & wrrst_n;
  always_comb begin
    wr_bin_d  = wr_bin_q + (ADDR_W + 1)'(wren);
    wr_gray_d = (ADDR_W + 1)'(bin2gray(32'(wr_bin_d)));
    full_d    = full_cmp(32'(wr_gray_d), 32'(rd_sync), ADDR_W);
    level_d   = wr_bin_d - (ADDR_W + 1)'(gray2bin(32'(rd_sync)));
    af_d      = level_d >= AF_TH;
  end
  always_ff @(posedge wrclk) begin
    if (!wrrst_n) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      level_q   <= level_d;
      full_q    <= full_d;
      af_q      <= af_d;
    end
  end
`ifdef FIFO_WR_OVF_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = ovf_q | (wr_req & full_q);
  always_ff @(posedge wrclk) ovf_q <= !wrrst_n ? 1'b0 : ovf_d;
  assign wr_ovf = ovf_q;
`endif
  assign wrPtr       = wr_bin_q[ADDR_W-1:0];
  assign wrPtrGray   = wr_gray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wr_level    = level_q;
endmodule
